// File: rtl/uart_word_reader.sv
// uart_word_reader: AXI4-Lite read master that polls an AXI UART Lite,
// pulls RX FIFO bytes one at a time and packs them little-endian into
// 32-bit words presented on a valid/ready stream.
//
// Ports:
//   clk, rst           clock, synchronous active-low reset
//   en                 permits new AXI reads when high
//   word_data/valid    assembled word and its valid flag
//   word_ready         consumer accepts the word
//   rx_err             sticky flag: a non-OKAY RRESP was seen since reset
//   ar*/r*             AXI4-Lite AR and R channels toward the UART
module uart_word_reader #(
  parameter int unsigned          AXI_ADDRW = 32,
  parameter int unsigned          AXI_DATAW = 32,
  parameter logic [AXI_ADDRW-1:0] BASE_ADDR = '0,
  parameter int unsigned          POLL_GAP  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  output logic [31:0]          word_data,
  output logic                 word_valid,
  input  logic                 word_ready,
  output logic                 rx_err,
  input  logic                 arready,
  output logic [AXI_ADDRW-1:0] araddr,
  output logic [2:0]           arprot,
  output logic                 arvalid,
  input  logic [AXI_DATAW-1:0] rdata,
  input  logic [1:0]           rresp,
  input  logic                 rvalid,
  output logic                 rready
);

  localparam int unsigned GAP_W    = (POLL_GAP > 2) ? $clog2(POLL_GAP) : 1;
  localparam int unsigned GAP_LAST = (POLL_GAP > 0) ? POLL_GAP - 1 : 0;
  localparam logic [AXI_ADDRW-1:0] RX_ADDR   = BASE_ADDR;
  localparam logic [AXI_ADDRW-1:0] STAT_ADDR = BASE_ADDR + AXI_ADDRW'(8);

  typedef enum logic [2:0] {
    IDLE, AR_STAT, R_STAT, GAP, AR_RX, R_RX, OUT
  } state_t;

  state_t             state_q, state_d, poll_state;
  logic [2:0]         byte_cnt_q, byte_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [31:0]        word_d;
  logic               rx_err_d;
  logic               ar_hs, r_hs;

  assign arprot = 3'b000;
  assign ar_hs  = arvalid & arready;
  assign r_hs   = rready & rvalid;

  // Only the low byte / STAT bit 0 of a read beat carries information.
  if (AXI_DATAW > 8) begin : g_unused
    logic unused_rdata;
    assign unused_rdata = ^rdata[AXI_DATAW-1:8];
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    word_d     = word_data;
    rx_err_d   = rx_err;
    poll_state = en ? AR_STAT : IDLE;

    case (state_q)
      IDLE: begin
        if (en) state_d = AR_STAT;
      end
      AR_STAT: begin
        if (ar_hs) state_d = R_STAT;
      end
      R_STAT: begin
        if (r_hs) begin
          if (rresp != 2'b00) rx_err_d = 1'b1;
          // The RX read is a new AR, so it also needs en.
          if (rresp == 2'b00 && rdata[0]) begin
            state_d = en ? AR_RX : IDLE;
          end else if (POLL_GAP == 0) begin
            state_d = poll_state;
          end else begin
            state_d   = GAP;
            gap_cnt_d = '0;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_LAST)) state_d = poll_state;
        else                               gap_cnt_d = gap_cnt_q + GAP_W'(1);
      end
      AR_RX: begin
        if (ar_hs) state_d = R_RX;
      end
      R_RX: begin
        if (r_hs) begin
          if (rresp == 2'b00) begin
            word_d[{byte_cnt_q[1:0], 3'b000} +: 8] = rdata[7:0];
            byte_cnt_d = byte_cnt_q + 3'd1;
          end else begin
            rx_err_d = 1'b1;
          end
          state_d = (byte_cnt_d == 3'd4) ? OUT : poll_state;
        end
      end
      OUT: begin
        if (word_ready) begin
          byte_cnt_d = '0;
          state_d    = poll_state;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs, derived from the next state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      gap_cnt_q  <= '0;
      word_data  <= '0;
      rx_err     <= 1'b0;
      arvalid    <= 1'b0;
      araddr     <= STAT_ADDR;
      rready     <= 1'b0;
      word_valid <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      word_data  <= word_d;
      rx_err     <= rx_err_d;
      arvalid    <= (state_d == AR_STAT) || (state_d == AR_RX);
      araddr     <= (state_d == AR_RX) ? RX_ADDR : STAT_ADDR;
      rready     <= (state_d == R_STAT) || (state_d == R_RX);
      word_valid <= (state_d == OUT);
    end
  end

endmodule

// File: tb/tb_uart_word_reader.sv
// Testbench for uart_word_reader: a scripted UART Lite slave answers the
// AXI reads; a reference model packs the scripted good bytes into words.
module tb_uart_word_reader;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned PG   = 4;
  localparam logic [31:0] BASE = 32'h4060_0000;

  logic          clk, rst, en;
  logic [31:0]   word_data;
  logic          word_valid, word_ready, rx_err;
  logic          arready, arvalid, rvalid, rready;
  logic [AW-1:0] araddr;
  logic [2:0]    arprot;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;

  uart_word_reader #(
    .AXI_ADDRW(AW), .AXI_DATAW(DW), .BASE_ADDR(BASE), .POLL_GAP(PG)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .rx_err(rx_err),
    .arready(arready), .araddr(araddr), .arprot(arprot), .arvalid(arvalid),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Slave scripts: stat entries {resp, bit0}; rx entries {resp, byte}.
  logic [2:0] stat_q[$];
  logic [9:0] rx_q[$];
  int ar_delay = 0, r_delay = 0;
  int stat_ars = 0, rx_ars = 0, rx_beats = 0, ar_hs_cnt = 0;

  // Reference model: good bytes in arrival order form LE words.
  logic [7:0]  mdl_bytes[$];
  logic [31:0] exp_words[$];
  logic        mdl_err = 1'b0;

  task automatic push_rx(input logic [1:0] resp, input logic [7:0] b);
    rx_q.push_back({resp, b});
    if (resp != 2'b00) mdl_err = 1'b1;
    else begin
      mdl_bytes.push_back(b);
      if (mdl_bytes.size() == 4) begin
        exp_words.push_back({mdl_bytes[3], mdl_bytes[2], mdl_bytes[1], mdl_bytes[0]});
        mdl_bytes.delete();
      end
    end
  endtask

  task automatic push_stat(input logic [1:0] resp, input logic b);
    stat_q.push_back({resp, b});
    if (resp != 2'b00) mdl_err = 1'b1;
  endtask

  // UART Lite slave: samples handshakes on posedge, drives on negedge.
  bit pending = 0, pend_rx = 0, beat_rx = 0, taken = 0, clr = 0;
  int ar_wait = 0, r_wait = 0;
  initial begin
    logic [2:0] s;
    logic [9:0] e;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    forever begin
      @(posedge clk);
      taken = rvalid && rready;
      if (!rst) begin
        pending = 0; clr = 1;
        stat_q.delete(); rx_q.delete();
      end else begin
        clr = 0;
        if (taken && beat_rx) rx_beats++;
        if (arvalid && arready) begin
          pending = 1; pend_rx = (araddr == BASE); r_wait = 0; ar_hs_cnt++;
          if (pend_rx) rx_ars++; else stat_ars++;
        end
      end
      @(negedge clk);
      if (taken || clr) rvalid = 1'b0;
      if (clr || !arvalid) ar_wait = 0; else ar_wait++;
      arready = (ar_delay == 0) || (ar_wait > ar_delay);
      if (pending && !rvalid) begin
        if (r_wait < r_delay) r_wait++;
        else if (!pend_rx) begin
          if (stat_q.size() > 0) s = stat_q.pop_front(); else s = 3'b001;
          rdata = $urandom(); rdata[0] = s[0]; rresp = s[2:1];
          rvalid = 1'b1; beat_rx = 0; pending = 0;
        end else if (rx_q.size() > 0) begin
          e = rx_q.pop_front();
          rdata = $urandom(); rdata[7:0] = e[7:0]; rresp = e[9:8];
          rvalid = 1'b1; beat_rx = 1; pending = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for a word, compare with the model, apply back-pressure, accept.
  task automatic get_word(input int hold, input bit keep_en, output int lat, output int idle);
    logic [31:0] d;
    lat = 0; idle = 0;
    while (!word_valid && lat < 2000) begin
      tick(); lat++;
      if (!word_valid && !arvalid && !rready) idle++;
    end
    if (!word_valid) begin
      check("word_timeout", word_valid, 1);
      return;
    end
    if (!keep_en) en = 1'b0;
    check("word_expected", exp_words.size() > 0, 1);
    if (exp_words.size() > 0) check("word_data", word_data, exp_words.pop_front());
    check("rx_err", rx_err, mdl_err);
    repeat (hold) begin
      d = word_data;
      tick();
      check("bp_arvalid", arvalid, 0);
      check("bp_valid", word_valid, 1);
      check("bp_data", word_data, d);
    end
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    check("accept_valid", word_valid, 0);
    check("accept_arvalid", arvalid, en);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_arvalid"}, arvalid, 0);
    check({tag, "_rready"}, rready, 0);
    check({tag, "_wvalid"}, word_valid, 0);
    check({tag, "_rx_err"}, rx_err, 0);
    check({tag, "_wdata"}, word_data, 0);
    check({tag, "_araddr"}, araddr, BASE + 32'h8);
    check({tag, "_arprot"}, arprot, 0);
  endtask

  initial begin
    int lat, idle, n, b0, a0, s0;
    rst = 1'b0; en = 1'b0; word_ready = 1'b0;
    repeat (3) tick();
    check_reset("reset");
    rst = 1'b1;
    tick();

    // Best-case word: 16 cycles of reads plus one to word_valid.
    push_rx(2'b00, 8'h11); push_rx(2'b00, 8'h22);
    push_rx(2'b00, 8'h33); push_rx(2'b00, 8'h44);
    en = 1'b1;
    get_word(0, 0, lat, idle);
    check("basic_latency", lat, 17);

    // Three empty STAT polls, each followed by POLL_GAP idle cycles.
    s0 = stat_ars;
    repeat (3) push_stat(2'b00, 1'b0);
    repeat (4) push_rx(2'b00, 8'hAB);
    en = 1'b1;
    get_word(0, 0, lat, idle);
    check("gap_idle_cycles", idle, 3 * PG);
    check("gap_stat_polls", stat_ars - s0, 7);

    // Second RX read errors: byte skipped, rx_err sticky.
    push_rx(2'b00, 8'h5A); push_rx(2'b10, 8'hEE);
    push_rx(2'b00, 8'h6B); push_rx(2'b00, 8'h7C); push_rx(2'b00, 8'h8D);
    en = 1'b1;
    get_word(0, 0, lat, idle);

    // en dropped after two bytes while a slow AR is pending.
    ar_delay = 5;
    b0 = rx_beats;
    push_rx(2'b00, 8'hC1); push_rx(2'b00, 8'hC2);
    push_rx(2'b00, 8'hC3); push_rx(2'b00, 8'hC4);
    en = 1'b1;
    n = 0;
    while (rx_beats != b0 + 2 && n < 500) begin tick(); n++; end
    check("en_drop_reach", rx_beats - b0, 2);
    check("en_drop_arvalid", arvalid, 1);
    check("en_drop_araddr", araddr, BASE + 32'h8);
    en = 1'b0;
    a0 = ar_hs_cnt;
    repeat (40) tick();
    check("en_drop_ar_count", ar_hs_cnt - a0, 1);
    check("en_drop_rx_beats", rx_beats - b0, 2);
    check("en_drop_idle", arvalid, 0);
    en = 1'b1;
    get_word(0, 0, lat, idle);
    ar_delay = 0;

    // Consumer stalls 20 cycles; en stays high.
    push_rx(2'b00, 8'hD0); push_rx(2'b00, 8'hD1);
    push_rx(2'b00, 8'hD2); push_rx(2'b00, 8'hD3);
    en = 1'b1;
    get_word(20, 1, lat, idle);

    // Reset while waiting on the fourth byte; partial word is discarded.
    a0 = rx_ars;
    push_rx(2'b00, 8'hE0); push_rx(2'b00, 8'hE1); push_rx(2'b00, 8'hE2);
    n = 0;
    while (!(rx_ars == a0 + 4 && rready) && n < 500) begin tick(); n++; end
    check("rst_reach_r_rx", rx_ars - a0, 4);
    rst = 1'b0; en = 1'b0;
    tick();
    check_reset("midrst");
    mdl_bytes.delete(); exp_words.delete(); mdl_err = 1'b0;
    rst = 1'b1;
    tick();
    push_rx(2'b00, 8'hF1); push_rx(2'b00, 8'hF2);
    push_rx(2'b00, 8'hF3); push_rx(2'b00, 8'hF4);
    en = 1'b1;
    get_word(0, 0, lat, idle);

    // Randomized words: empty/error STAT polls, RX errors, slave delays.
    en = 1'b1;
    for (int w = 0; w < 8; w++) begin
      int k, good;
      ar_delay = $urandom_range(0, 3);
      r_delay  = $urandom_range(0, 3);
      k = $urandom_range(0, 2);
      for (int i = 0; i < k; i++) begin
        if ($urandom_range(0, 3) == 0) push_stat(2'($urandom_range(1, 3)), 1'($urandom));
        else                           push_stat(2'b00, 1'b0);
      end
      good = 0;
      while (good < 4) begin
        if (good > 0 && $urandom_range(0, 5) == 0) push_rx(2'($urandom_range(1, 3)), 8'($urandom));
        else begin push_rx(2'b00, 8'($urandom)); good++; end
      end
      get_word($urandom_range(0, 4), 1, lat, idle);
    end
    check("words_left", exp_words.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
